instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Encodes RISC-V R/I/S/B/U/J instruction fields into a 32-bit word. The encoded
// words, each tagged with an illegal-field flag, are queued in a small FIFO.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               fmt,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [31:0]              imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_sticky
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          active;
    logic          sticky;
    logic [32:0]   mem [DEPTH];
    logic [32:0]   enc_p0;
    logic          push;
    logic          pop;

    // Returns {err, word}; illegal immediates are truncated into the word, not rejected.
    function automatic logic [32:0] encode(
        input logic [2:0]         f,
        input logic [6:0]         op,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic [4:0]         d,
        input logic [4:0]         s1,
        input logic [4:0]         s2,
        input logic signed [31:0] im
    );
        logic [31:0] w;
        logic        e;
        w = '0;
        e = 1'b0;
        case (f)
            3'd0: w = {f7, s2, s1, f3, d, op};
            3'd1: begin
                w = {im[11:0], s1, f3, d, op};
                e = (im != {{20{im[11]}}, im[11:0]});
            end
            3'd2: begin
                w = {im[11:5], s2, s1, f3, im[4:0], op};
                e = (im != {{20{im[11]}}, im[11:0]});
            end
            3'd3: begin
                w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
                e = im[0] || (im != {{19{im[12]}}, im[12:0]});
            end
            3'd4: begin
                w = {im[31:12], d, op};
                e = (im[11:0] != 12'd0);
            end
            3'd5: begin
                w = {im[20], im[10:1], im[11], im[19:12], d, op};
                e = im[0] || (im != {{11{im[20]}}, im[20:0]});
            end
            default: begin
                w = '0;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    assign enc_p0   = encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
    assign in_ready = active && (cnt < FULL) && !clear;
    assign push     = in_valid && in_ready;
    assign out_valid = (cnt != '0);
    assign pop      = out_valid && out_ready;

    // Stage p0 -> FIFO storage: word and err flag registered on accept
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_p0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else begin
            active <= 1'b1;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                if (push && enc_p0[32]) begin
                    sticky <= 1'b1;
                end
            end
        end
    end

    // Head is masked to zero when empty so reset clears the outputs immediately
    assign out_instr  = out_valid ? mem[rd_ptr][31:0] : 32'd0;
    assign out_err    = out_valid ? mem[rd_ptr][32] : 1'b0;
    assign level      = cnt;
    assign err_sticky = sticky;

endmodule
